inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 4, largest program length in 32-bit words that the loader accepts.
REQ-002 Parameter: BASE_ADDR, default 32'h0, byte address of the first instruction word written.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-low.
REQ-005 Port: byte_valid  input  1  producer has a load-stream byte on byte_data.
REQ-006 Port: byte_data  input  8  load-stream byte.
REQ-007 Port: byte_ready  output  1  loader accepts byte_data this cycle; a byte transfers when byte_valid and byte_ready are both 1.
REQ-008 Port: imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 Port: imem_addr  output  32  byte address of the word being written.
REQ-010 Port: imem_wdata  output  32  instruction word being written.
REQ-011 Port: core_rst  output  1  active-high reset for the processor's program counter; held at 1 until a load completes.
REQ-012 Port: done  output  1  load completed and checksum matched (sticky).
REQ-013 Port: err  output  1  load aborted on a length or checksum error (sticky).

Function
REQ-014 Stream format SHALL be: count_lo, count_hi (16-bit word count, little-endian), then count×4 data bytes, then 1 checksum byte.
REQ-015 FSM states SHALL be HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR; one byte transfer advances HDR_LO→HDR_HI→(DATA, or CHECK if count=0)→…→CHECK.
REQ-016 byte_ready SHALL be 1 in HDR_LO, HDR_HI, DATA and CHECK, and 0 in DONE and ERROR.
REQ-017 A count greater than MAX_WORDS SHALL move the FSM from HDR_HI to ERROR on the cycle after count_hi is accepted, with no memory writes.
REQ-018 Data bytes SHALL pack little-endian: the first byte of each word goes to wdata[7:0] and the fourth to wdata[31:24].
REQ-019 imem_we SHALL pulse for exactly one cycle, in the cycle after the 4th byte of a word is accepted; imem_wdata and imem_addr SHALL be valid in that same cycle.
REQ-020 imem_addr for word k (0-based) SHALL be BASE_ADDR + 4·k, computed modulo 2^32.
REQ-021 imem_we SHALL be 0 in every other cycle; imem_addr and imem_wdata hold their last values when no write is in progress.
REQ-022 The checksum SHALL be the XOR of all data bytes only; header bytes are excluded. A count of 0 expects a checksum of 8'h00.
REQ-023 On a matching checksum, the cycle after acceptance SHALL enter DONE with done=1 and core_rst=0.
REQ-024 On a mismatching checksum, the cycle after acceptance SHALL enter ERROR with err=1 and core_rst=1.
REQ-025 The FSM SHALL stay in DONE or ERROR until reset; byte_valid SHALL be ignored in those states.
REQ-026 The FSM SHALL not advance on cycles where byte_valid=0 (producer stalls); any gap length between bytes SHALL be tolerated.
REQ-027 The final word's imem_we pulse SHALL occur before or in the same cycle as the checksum acceptance, never after DONE is entered.

Reset
REQ-028 While rst=0 at a rising edge, the loader SHALL set: state=HDR_LO, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst=1, done=0, err=0, and clear all counters and the checksum.
REQ-029 Reset mid-load SHALL abort the load with no further writes; words already written are not erased.
REQ-030 byte_ready SHALL be gated to 0 in any cycle where rst=0.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the header width (16), and the default MAX_WORDS.
REQ-032 The byte-to-word assembly (2-bit byte index, 32-bit shift register, word-complete flag) SHALL be one sub-module named byte_packer; the rest lives in inst_loader.

Verification
REQ-033 Stream 01 00 03 A3 C4 FF 9B, with valid held high → one imem_we pulse with addr=0, wdata=32'hFFC4A303; then done=1, core_rst=0, byte_ready=0.
REQ-034 Same stream with checksum 9A → no change to the single write; then err=1, done=0, core_rst=1.
REQ-035 Stream 05 00, with MAX_WORDS=4 → ERROR one cycle after the 2nd byte, zero imem_we pulses, err=1.
REQ-036 Stream 00 00 00 → DONE with zero writes and done=1; a 4th byte offered afterwards is not accepted.
REQ-037 Stream 02 00 followed by 8 data bytes with random valid gaps, and BASE_ADDR=32'h10 → writes at addresses 10 and 14 with correct little-endian words; done=1 after the correct checksum.
REQ-038 rst pulled low after 3 data bytes, then a full valid stream → the first partial word is never written; the second load behaves exactly as in REQ-033.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Holds the FSM encoding, header width and default program size.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_W         = 16;
    localparam int DEF_MAX_WORDS = 4;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Assembles accepted data bytes into little-endian 32-bit words.
// word_next/word_done describe the word completed by the current byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_done
);

    logic [1:0]  idx;
    logic [31:0] shreg;

    // New bytes enter at the top so the first byte ends up in [7:0]
    assign word_next = {byte_data, shreg[31:8]};
    assign word_done = take && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx   <= '0;
            shreg <= '0;
        end else if (take) begin
            idx   <= idx + 2'd1;
            shreg <= word_next;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed, XOR-checked program into instruction memory
// and releases the core from reset once the image is verified.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam logic [HDR_W:0] MAX_LIM = (HDR_W + 1)'(MAX_WORDS);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              take;
    logic [7:0]        cnt_lo;
    logic [HDR_W-1:0]  count;
    logic [HDR_W-1:0]  hdr_count;
    logic [HDR_W-1:0]  wcnt;
    logic [7:0]        csum;
    logic [31:0]       next_addr;
    logic [31:0]       word_next;
    logic              word_done;
    logic              too_long;
    logic              last_word;

    assign accept    = byte_valid && byte_ready;
    assign take      = accept && (state == DATA);
    assign hdr_count = {byte_data, cnt_lo};
    assign too_long  = {1'b0, hdr_count} > MAX_LIM;
    assign last_word = word_done && (wcnt == count - 1'b1);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .take      (take),
        .byte_data (byte_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= HDR_LO;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            HDR_LO: if (accept) state_n = HDR_HI;
            HDR_HI: begin
                if (accept) begin
                    if (too_long)
                        state_n = ERROR;
                    else if (hdr_count == '0)
                        state_n = CHECK;
                    else
                        state_n = DATA;
                end
            end
            DATA:   if (last_word) state_n = CHECK;
            CHECK: begin
                if (accept)
                    state_n = (byte_data == csum) ? DONE : ERROR;
            end
            DONE:    state_n = DONE;
            ERROR:   state_n = ERROR;
            default: state_n = HDR_LO;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b1;
        unique case (state)
            HDR_LO, HDR_HI, DATA, CHECK: byte_ready = rst;
            DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
            end
            ERROR:   err = 1'b1;
            default: ;
        endcase
    end

    // Write port registers hold their values between word strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            next_addr  <= BASE_ADDR;
            cnt_lo     <= '0;
            count      <= '0;
            wcnt       <= '0;
            csum       <= '0;
        end else begin
            imem_we <= word_done;
            if (word_done) begin
                imem_addr  <= next_addr;
                imem_wdata <= word_next;
                next_addr  <= next_addr + 32'd4;
                wcnt       <= wcnt + 1'b1;
            end
            if (accept && state == HDR_LO) cnt_lo <= byte_data;
            if (accept && state == HDR_HI) count <= hdr_count;
            if (take) csum <= csum ^ byte_data;
        end
    end

endmodule
